// File: rtl/r2r_dac_sequencer.sv
// Sample-rate divider and waveform/stream source driving an 8-bit R2R DAC.
// Optional feature: define R2R_SEQ_SYNC_EN to add the wave_sync wrap/turn pulse output.
module r2r_dac_sequencer #(
    parameter int unsigned DEFAULT_DIV  = 9,
    parameter int unsigned DEFAULT_STEP = 1,
    parameter logic [7:0]  IDLE_CODE    = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       sample_tick,
    output logic       underrun,
`ifdef R2R_SEQ_SYNC_EN
    output logic       wave_sync,
`endif
    output logic [7:0] r2r_out
);

    typedef enum logic [2:0] {
        ModeOff    = 3'd0,
        ModeRamp   = 3'd1,
        ModeTri    = 3'd2,
        ModeSquare = 3'd3,
        ModeStream = 3'd4
    } mode_e;

    localparam logic [7:0] DivRst  = 8'(DEFAULT_DIV);
    localparam logic [7:0] StepRst = 8'(DEFAULT_STEP);

    logic [7:0] div_q, cnt_q, step_q, phase_q, buf_q;
    logic       dir_q;      // 0 = up, 1 = down (TRI only)
    logic       buf_full_q;
    mode_e      mode_q;

    logic [7:0] step_eff;
    logic [8:0] phase_sum;
    logic [7:0] phase_diff;
    logic       tri_top, tri_bottom;
    logic [7:0] phase_nxt;
    logic       dir_nxt;
    logic       accept;
    mode_e      mode_wr;

    assign sample_tick = (cnt_q == 8'd0);
    assign s_ready     = (mode_q == ModeStream) && (!buf_full_q || sample_tick);
    assign accept      = s_valid && s_ready;
    assign underrun    = sample_tick && (mode_q == ModeStream) && !buf_full_q;
    assign mode_wr     = (cfg_data[2:0] > 3'd4) ? ModeOff : mode_e'(cfg_data[2:0]);

    always_comb begin
        step_eff   = (step_q == 8'd0) ? 8'd1 : step_q;
        phase_sum  = {1'b0, phase_q} + {1'b0, step_eff};
        phase_diff = phase_q - step_eff;
        tri_top    = phase_sum[8];
        tri_bottom = (phase_q < step_eff);
        phase_nxt  = phase_q;
        dir_nxt    = dir_q;
        case (mode_q)
            ModeRamp, ModeSquare: phase_nxt = phase_sum[7:0];
            ModeTri: begin
                if (!dir_q) begin
                    if (tri_top) begin
                        phase_nxt = 8'hFF;
                        dir_nxt   = 1'b1;
                    end else begin
                        phase_nxt = phase_sum[7:0];
                    end
                end else if (tri_bottom) begin
                    phase_nxt = 8'h00;
                    dir_nxt   = 1'b0;
                end else begin
                    phase_nxt = phase_diff;
                end
            end
            default: ;
        endcase
    end

`ifdef R2R_SEQ_SYNC_EN
    // Wrap carry for RAMP/SQUARE, bottom turn for TRI, a real sample emitted for STREAM.
    assign wave_sync = sample_tick &&
        ((((mode_q == ModeRamp) || (mode_q == ModeSquare)) && phase_sum[8]) ||
         ((mode_q == ModeTri) && dir_q && tri_bottom) ||
         ((mode_q == ModeStream) && buf_full_q));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= DivRst;
            cnt_q      <= DivRst;
            step_q     <= StepRst;
            phase_q    <= 8'd0;
            dir_q      <= 1'b0;
            buf_q      <= 8'd0;
            buf_full_q <= 1'b0;
            mode_q     <= ModeOff;
            r2r_out    <= IDLE_CODE;
        end else begin
            cnt_q <= sample_tick ? div_q : cnt_q - 8'd1;

            if (sample_tick) begin
                phase_q <= phase_nxt;
                dir_q   <= dir_nxt;
                case (mode_q)
                    ModeRamp, ModeTri: r2r_out <= phase_nxt;
                    ModeSquare:        r2r_out <= phase_nxt[7] ? 8'hFF : 8'h00;
                    ModeStream:        if (buf_full_q) r2r_out <= buf_q;
                    default: ;
                endcase
            end
            if (mode_q == ModeOff) r2r_out <= IDLE_CODE;

            // A same-cycle accept refills the slot the tick just drained.
            if (accept) begin
                buf_q      <= s_data;
                buf_full_q <= 1'b1;
            end else if (sample_tick && buf_full_q) begin
                buf_full_q <= 1'b0;
            end

            // Config writes come last so they win over tick updates.
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0: begin
                        div_q <= cfg_data;
                        cnt_q <= cfg_data;
                    end
                    2'd1: begin
                        mode_q     <= mode_wr;
                        phase_q    <= 8'd0;
                        dir_q      <= 1'b0;
                        cnt_q      <= div_q;
                        buf_full_q <= 1'b0;
                        if (mode_wr == ModeOff) r2r_out <= IDLE_CODE;
                    end
                    2'd2: step_q <= cfg_data;
                    default: begin
                        phase_q <= cfg_data;
                        dir_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_r2r_dac_sequencer.sv
// Self-checking bench for r2r_dac_sequencer: directed scenarios plus randomized waveform and
// stream runs against a behavioural model. Define R2R_SEQ_SYNC_EN to also cover wave_sync.
module tb_r2r_dac_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready, sample_tick, underrun;
    logic [7:0] r2r_out;
`ifdef R2R_SEQ_SYNC_EN
    logic       wave_sync;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    bit         sync_q[$];
    bit         tbl_valid[8];
    logic [7:0] tbl_data[8];

    r2r_dac_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .sample_tick(sample_tick),
        .underrun   (underrun),
`ifdef R2R_SEQ_SYNC_EN
        .wave_sync  (wave_sync),
`endif
        .r2r_out    (r2r_out)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // All tasks start and end just after a falling edge.
    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (sample_tick === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Expected code (and sync flag) for each tick after a mode entry, from phase p0.
    task automatic build_ref(input int mode, input int step, input int p0, input int n);
        int s, v;
        bit down, wrap;
        s = (step == 0) ? 1 : step;
        v = p0;
        down = 1'b0;
        exp_q.delete();
        sync_q.delete();
        for (int k = 0; k < n; k++) begin
            wrap = 1'b0;
            if (mode == 2) begin
                if (!down) begin
                    if (v + s > 255) begin v = 255; down = 1'b1; end
                    else v = v + s;
                end else if (v < s) begin
                    v = 0; down = 1'b0; wrap = 1'b1;
                end else begin
                    v = v - s;
                end
                exp_q.push_back(8'(v));
            end else begin
                wrap = (v + s) > 255;
                v = (v + s) % 256;
                exp_q.push_back((mode == 3) ? ((v >= 128) ? 8'hFF : 8'h00) : 8'(v));
            end
            sync_q.push_back(wrap);
        end
    endtask

    task automatic run_wave(input string name, input int div, input int n);
        bit ok;
        int last;
        last = 0;
        for (int k = 0; k < n; k++) begin
            wait_tick(ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL %s tick %0d: no sample_tick within 300 cycles", name, k);
                return;
            end
            if (k > 0) begin
                tests++;
                if (cyc - last != div + 1) begin
                    fails++;
                    $display("FAIL %s period %0d: got %0d cycles, want %0d", name, k,
                             cyc - last, div + 1);
                end
                tests++;
                if (r2r_out !== exp_q[k-1]) begin
                    fails++;
                    $display("FAIL %s latency %0d: got %h, want %h", name, k, r2r_out,
                             exp_q[k-1]);
                end
            end
`ifdef R2R_SEQ_SYNC_EN
            tests++;
            if (wave_sync !== sync_q[k]) begin
                fails++;
                $display("FAIL %s wave_sync %0d: got %b, want %b", name, k, wave_sync, sync_q[k]);
            end
`endif
            last = cyc;
            @(negedge clk);
            tests++;
            if (r2r_out !== exp_q[k]) begin
                fails++;
                $display("FAIL %s code %0d: got %h, want %h", name, k, r2r_out, exp_q[k]);
            end
        end
    endtask

    task automatic stream_run(input string name, input int div, input int n, input bit directed);
        bit full, v, tick, rdy;
        logic [7:0] b, d, exp_out;
        cfg_write(2'd1, 8'd0);
        cfg_write(2'd0, 8'(div));
        cfg_write(2'd1, 8'd4);
        full = 1'b0;
        b = 8'd0;
        exp_out = 8'h80;
        for (int m = 0; m < n; m++) begin
            if (directed) begin
                v = tbl_valid[m];
                d = tbl_data[m];
            end else begin
                v = ($urandom % 3) != 0;
                d = 8'($urandom);
            end
            s_valid = v;
            s_data  = d;
            tick = (m % (div + 1)) == div;
            rdy  = !full || tick;
            tests += 3;
            if (sample_tick !== tick) begin
                fails++;
                $display("FAIL %s tick @%0d: got %b, want %b", name, m, sample_tick, tick);
            end
            if (s_ready !== rdy) begin
                fails++;
                $display("FAIL %s s_ready @%0d: got %b, want %b", name, m, s_ready, rdy);
            end
            if (underrun !== (tick && !full)) begin
                fails++;
                $display("FAIL %s underrun @%0d: got %b, want %b", name, m, underrun,
                         tick && !full);
            end
`ifdef R2R_SEQ_SYNC_EN
            tests++;
            if (wave_sync !== (tick && full)) begin
                fails++;
                $display("FAIL %s wave_sync @%0d: got %b, want %b", name, m, wave_sync,
                         tick && full);
            end
`endif
            if (tick && full) begin
                exp_out = b;
                full = 1'b0;
            end
            if (v && rdy) begin
                b = d;
                full = 1'b1;
            end
            @(negedge clk);
            tests++;
            if (r2r_out !== exp_out) begin
                fails++;
                $display("FAIL %s r2r_out @%0d: got %h, want %h", name, m, r2r_out, exp_out);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        int c0;
        repeat (3) @(negedge clk);
        tests += 4;
        if (r2r_out !== 8'h80) begin fails++; $display("FAIL reset r2r_out: got %h, want 80", r2r_out); end
        if (s_ready !== 1'b0) begin fails++; $display("FAIL reset s_ready: got %b, want 0", s_ready); end
        if (sample_tick !== 1'b0) begin fails++; $display("FAIL reset tick: got %b, want 0", sample_tick); end
        if (underrun !== 1'b0) begin fails++; $display("FAIL reset underrun: got %b, want 0", underrun); end
        rst = 1'b0;
        c0 = cyc;
        wait_tick(ok);
        tests++;
        if (!ok || cyc - c0 != 9) begin
            fails++;
            $display("FAIL reset first tick: got %0d cycles, want 9", cyc - c0);
        end
        @(negedge clk);
        c0 = cyc - 1;
        wait_tick(ok);
        tests += 2;
        if (!ok || cyc - c0 != 10) begin
            fails++;
            $display("FAIL reset period: got %0d cycles, want 10", cyc - c0);
        end
        if (r2r_out !== 8'h80) begin fails++; $display("FAIL reset idle code: got %h, want 80", r2r_out); end
        @(negedge clk);
    endtask

    task automatic test_ramp();
        bit ok;
        int last;
        cfg_write(2'd0, 8'd3);
        cfg_write(2'd2, 8'd64);
        cfg_write(2'd1, 8'd1);
        build_ref(1, 64, 0, 5);
        exp_q = '{8'd64, 8'd128, 8'd192, 8'd0, 8'd64};
        run_wave("ramp", 3, 5);
        // DIV write landing on a tick: tick still updates the code, reload uses the new div.
        wait_tick(ok);
        cfg_write(2'd0, 8'd2);
        tests++;
        if (!ok || r2r_out !== 8'd128) begin
            fails++;
            $display("FAIL div_on_tick code: got %h, want 80", r2r_out);
        end
        last = cyc;
        wait_tick(ok);
        tests++;
        if (!ok || cyc - last != 2) begin
            fails++;
            $display("FAIL div_on_tick reload: got %0d cycles, want 2", cyc - last);
        end
        @(negedge clk);
    endtask

    task automatic test_tri_square();
        cfg_write(2'd2, 8'd100);
        cfg_write(2'd1, 8'd2);
        build_ref(2, 100, 0, 7);
        exp_q = '{8'd100, 8'd200, 8'd255, 8'd155, 8'd55, 8'd0, 8'd100};
        run_wave("tri", 2, 7);
        cfg_write(2'd2, 8'd128);
        cfg_write(2'd1, 8'd3);
        build_ref(3, 128, 0, 3);
        exp_q = '{8'hFF, 8'h00, 8'hFF};
        run_wave("square", 2, 3);
`ifdef R2R_SEQ_SYNC_EN
        cfg_write(2'd1, 8'd1);
        build_ref(1, 128, 0, 4);
        run_wave("sync_ramp", 2, 4);
`endif
    endtask

    task automatic test_random_wave();
        int div, mode, step, p0;
        for (int it = 0; it < 8; it++) begin
            div  = $urandom_range(0, 4);
            mode = $urandom_range(1, 3);
            step = (it == 0) ? 0 : $urandom_range(0, 255);
            p0   = (div > 0 && ($urandom % 2) == 1) ? $urandom_range(0, 255) : 0;
            cfg_write(2'd0, 8'(div));
            cfg_write(2'd2, 8'(step));
            cfg_write(2'd1, 8'(mode));
            if (p0 != 0) cfg_write(2'd3, 8'(p0));
            build_ref(mode, step, p0, 8);
            run_wave("rand_wave", div, 8);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            tbl_valid[i] = (i < 2);
            tbl_data[i]  = 8'h00;
        end
        tbl_data[0] = 8'hA5;
        tbl_data[1] = 8'h5A;
        stream_run("stream_b2b", 1, 8, 1'b1);
        tests++;
        if (r2r_out !== 8'h5A) begin
            fails++;
            $display("FAIL stream_b2b hold: got %h, want 5a", r2r_out);
        end
        for (int it = 0; it < 3; it++) stream_run("rand_stream", $urandom_range(0, 3), 30, 1'b0);
    endtask

    task automatic test_flush_off();
        bit ok;
        cfg_write(2'd1, 8'd0);
        cfg_write(2'd0, 8'd5);
        cfg_write(2'd1, 8'd4);
        s_valid = 1'b1;
        s_data  = 8'h33;
        @(negedge clk);
        s_valid = 1'b0;
        wait_tick(ok);
        @(negedge clk);
        tests++;
        if (!ok || r2r_out !== 8'h33) begin fails++; $display("FAIL flush first: got %h, want 33", r2r_out); end
        s_valid = 1'b1;
        s_data  = 8'h44;
        @(negedge clk);
        s_valid = 1'b0;
        cfg_write(2'd1, 8'd4);
        tests++;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL flush s_ready: got %b, want 1", s_ready); end
        wait_tick(ok);
        tests++;
        if (!ok || underrun !== 1'b1) begin fails++; $display("FAIL flush underrun: got %b, want 1", underrun); end
        @(negedge clk);
        tests++;
        if (r2r_out !== 8'h33) begin fails++; $display("FAIL flush hold: got %h, want 33", r2r_out); end
        cfg_write(2'd1, 8'd0);
        tests++;
        if (r2r_out !== 8'h80) begin fails++; $display("FAIL off code: got %h, want 80", r2r_out); end
        // Undefined mode 7 decodes as OFF.
        cfg_write(2'd0, 8'd2);
        cfg_write(2'd1, 8'd1);
        build_ref(1, 1, 0, 2);
        run_wave("pre_off7", 2, 2);
        cfg_write(2'd1, 8'd7);
        tests++;
        if (r2r_out !== 8'h80) begin fails++; $display("FAIL mode7 code: got %h, want 80", r2r_out); end
        wait_tick(ok);
        @(negedge clk);
        tests += 2;
        if (!ok || r2r_out !== 8'h80) begin fails++; $display("FAIL mode7 hold: got %h, want 80", r2r_out); end
        if (s_ready !== 1'b0) begin fails++; $display("FAIL mode7 s_ready: got %b, want 0", s_ready); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int c0;
        cfg_write(2'd2, 8'd64);
        cfg_write(2'd1, 8'd1);
        wait_tick(ok);
        @(negedge clk);
        #10 rst = 1'b1;
        #1;
        tests += 2;
        if (r2r_out !== 8'h80) begin fails++; $display("FAIL async_reset code: got %h, want 80", r2r_out); end
        if (sample_tick !== 1'b0) begin fails++; $display("FAIL async_reset tick: got %b, want 0", sample_tick); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        c0 = cyc;
        wait_tick(ok);
        tests++;
        if (!ok || cyc - c0 != 9) begin
            fails++;
            $display("FAIL async_reset div: got %0d cycles, want 9", cyc - c0);
        end
        @(negedge clk);
        // Step and phase back at defaults: ramp 1,2,3.
        cfg_write(2'd1, 8'd1);
        build_ref(1, 1, 0, 3);
        exp_q = '{8'd1, 8'd2, 8'd3};
        run_wave("post_reset_ramp", 9, 3);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_ramp();
        test_tri_square();
        test_random_wave();
        test_back_to_back();
        test_flush_off();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
